sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side controller feeding the MEM stage: converts the pipeline's single-cycle 32-bit load/store requests into two sequential 16-bit accesses on the board's external asynchronous SRAM (256K x 16). It deasserts `ready` while an access is in flight so the top level can freeze every pipeline register until the word is complete.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM halfword 0.
- `SRAM_AW`, 18: SRAM halfword address width.

- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  store request from MEM stage.
- `rd_en`  in  1  load request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load data, registered.
- `ready`  out  1  0 = pipeline must freeze; combinational.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  SRAM_AW  SRAM halfword address.
- `SRAM_WE_N`  out  1  write strobe, active low.
- `SRAM_OE_N`  out  1  output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied 0.

## Operation
- Word index `wa = (address - BASE_ADDR) >> 2`; low halfword at `{wa,0}`, high halfword at `{wa,1}`, both truncated to SRAM_AW bits (out-of-range addresses wrap, no error).
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: `wr_en` or `rd_en` -> LOW, latching operation, address and `write_data`. `wr_en` has priority if both are asserted (access is a write).
  - LOW: drive low halfword address -> HIGH.
  - HIGH: drive high halfword address -> DONE.
  - DONE: -> IDLE unconditionally.
- Read: `SRAM_OE_N`=0 in LOW/HIGH; `read_data[15:0]` captured from `SRAM_DQ` at end of LOW, `[31:16]` at end of HIGH. `read_data` holds its value until the next read.
- Write: `SRAM_DQ` driven with `write_data[15:0]` in LOW and `[31:16]` in HIGH; `SRAM_WE_N`=0 in those states. `SRAM_DQ` is high-Z in every other state and for all reads.
- `ready = ~(wr_en | rd_en) | (state == DONE)`.
- Request dropped mid-access: the access still completes through DONE; no abort.
- Reset (any state): FSM -> IDLE, `read_data`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ` high-Z. All take effect immediately, with no clock edge required. A write cut by reset leaves SRAM contents undefined for that word.

## Timing
- No request: `ready`=1, zero latency.
- Request seen in cycle 0 (IDLE): `ready`=0 in cycles 0-2, LOW=1, HIGH=2, DONE=3 with `ready`=1. The pipeline advances at the end of cycle 3, so a load/store costs 3 freeze cycles.
- `read_data` is valid from cycle 3 onward.
- Back-to-back requests: IDLE is revisited for one cycle; the next request's cycle 0 is cycle 4.

## Configuration
- `SRAM_WAIT_EN` defined: LOW and HIGH each last 2 cycles (setup + strobe). `SRAM_WE_N`=0 only in the second cycle; read data is captured at the end of the second cycle. DONE moves to cycle 5 (5 freeze cycles).
- Undefined: single-cycle phases as described above.

## Test plan
- Reset asserted mid-HIGH of a write -> `SRAM_WE_N`=1, `SRAM_DQ`=Z, `read_data`=0, and the FSM is in IDLE before the next edge.
- Store 0xDEADBEEF at 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; `ready` is low for 3 cycles, then high in the 4th.
- Load from 1028 with SRAM[2]=0x5678, SRAM[3]=0x1234 -> `read_data`=0x12345678 in cycle 3.
- Store 0xA5A5_0F0F at 1040, then load from 1040 back-to-back -> 0xA5A50F0F, with the second request starting at cycle 4.
- `rd_en`=`wr_en`=1 at 1024 with data 0x1 -> a write occurs, `SRAM_OE_N` stays 1, and SRAM[0]=0x0001.
- With `SRAM_WAIT_EN`, load from 1028 -> `ready` is low for 5 cycles, and `SRAM_WE_N`/`SRAM_OE_N` timing matches the setup+strobe rules.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: turns single-cycle 32-bit loads/stores into two 16-bit async SRAM accesses,
// holding ready low until the word completes. Define SRAM_WAIT_EN for two-cycle (setup + strobe) phases.

module sram_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [SRAM_AW-2:0] wa_q, wa_d, wa_in;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               active;
  logic               strobe;

  // Word index relative to BASE_ADDR; out-of-range addresses simply wrap.
  assign wa_in  = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
  assign active = (state_q == S_LOW) || (state_q == S_HIGH);

`ifdef SRAM_WAIT_EN
  logic strobe_q, strobe_d;

  // Each phase spends one setup cycle (strobe_q=0) before its strobe cycle.
  assign strobe_d = active & ~strobe_q;
  assign strobe   = strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobe_q <= 1'b0;
    else     strobe_q <= strobe_d;
  end
`else
  assign strobe = 1'b1;
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    write_d = write_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          state_d = S_LOW;
          write_d = wr_en;
          wa_d    = wa_in;
          wdata_d = write_data;
        end
      end
      S_LOW: begin
        if (strobe) begin
          state_d = S_HIGH;
          if (!write_q) rdata_d[15:0] = SRAM_DQ;
        end
      end
      S_HIGH: begin
        if (strobe) begin
          state_d = S_DONE;
          if (!write_q) rdata_d[31:16] = SRAM_DQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs decode from state so an async reset returns them to idle at once.
  assign SRAM_ADDR = active ? {wa_q, (state_q == S_HIGH)} : '0;
  assign SRAM_WE_N = ~(active & write_q & strobe);
  assign SRAM_OE_N = ~(active & ~write_q);
  assign SRAM_DQ   = (active && write_q) ? ((state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                                         : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign read_data = rdata_q;
  assign ready     = ~(wr_en | rd_en) | (state_q == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus an address-arithmetic reference model.
// Honours SRAM_WAIT_EN the same way the design does.

module tb_sram_controller;

`ifdef SRAM_WAIT_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int          AW   = 18;
  localparam int unsigned BASE = 1024;
  localparam int          NCYC = 2 * PH + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  sram_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM; probe_en lets the bench drive a marker to prove the DUT has released the bus.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic        probe_en;
  logic        tb_en;
  logic [15:0] tb_val;
  assign tb_en   = (!oe_n && we_n) || probe_en;
  assign tb_val  = probe_en ? 16'h3C3C : sram_mem[sram_addr];
  assign sram_dq = tb_en ? tb_val : 16'hzzzz;

  always @(posedge clk) if (!we_n) sram_mem[sram_addr] <= sram_dq;

  // Reference model
  logic [15:0] ref_mem [int unsigned];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_read;

  function automatic logic [15:0] init_pat(input int unsigned i);
    logic [31:0] v;
    v = i;
    return v[15:0] ^ 16'hC3A5;
  endfunction

  function automatic int unsigned lo_idx(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return ((off >> 2) % (1 << (AW - 1))) * 2;
  endfunction

  function automatic logic [15:0] ref_rd(input int unsigned i);
    return ref_mem.exists(i) ? ref_mem[i] : init_pat(i);
  endfunction

  // One full transaction, entered and left at a falling edge; the request stays asserted on return.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic [31:0] we_tr, oe_tr, exp_we, exp_oe, rdat, exp_rd;
    logic        addr_bad, seen;
    int          freeze;
    int unsigned lo;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    lo = lo_idx(a);
    we_tr = '1; oe_tr = '1; addr_bad = 1'b0; seen = 1'b0; freeze = 0; rdat = '0;
    for (int c = 0; c < 24; c++) begin
      #1;
      we_tr[c] = we_n;
      oe_tr[c] = oe_n;
      if (c >= 1 && c <= 2 * PH && sram_addr !== AW'(lo + (c - 1) / PH)) addr_bad = 1'b1;
      if (ready === 1'b1) begin
        seen = 1'b1;
        rdat = read_data;
        break;
      end
      freeze++;
      @(negedge clk);
    end
    exp_we = '1; exp_oe = '1;
    for (int c = 1; c <= 2 * PH; c++) begin
      if (wr && ((c - 1) % PH == PH - 1)) exp_we[c] = 1'b0;
      if (!wr) exp_oe[c] = 1'b0;
    end
    n_checks++;
    if (!seen || freeze != 2 * PH + 1) begin
      n_fail++;
      $display("FAIL %s freeze: got %0d (ready seen=%0b) expected %0d", name, freeze, seen, 2 * PH + 1);
    end
    n_checks++;
    if (we_tr[NCYC-1:0] !== exp_we[NCYC-1:0] || oe_tr[NCYC-1:0] !== exp_oe[NCYC-1:0]) begin
      n_fail++;
      $display("FAIL %s strobes: we_n=%b oe_n=%b expected we_n=%b oe_n=%b", name,
               we_tr[NCYC-1:0], oe_tr[NCYC-1:0], exp_we[NCYC-1:0], exp_oe[NCYC-1:0]);
    end
    n_checks++;
    if (addr_bad) begin
      n_fail++;
      $display("FAIL %s sram_addr: wrong halfword address, expected %0d then %0d", name, lo, lo + 1);
    end
    if (wr) begin
      ref_mem[lo]     = d[15:0];
      ref_mem[lo + 1] = d[31:16];
      n_checks++;
      if (sram_mem[lo] !== ref_mem[lo] || sram_mem[lo + 1] !== ref_mem[lo + 1]) begin
        n_fail++;
        $display("FAIL %s write: sram[%0d]=%h sram[%0d]=%h expected %h %h", name, lo, sram_mem[lo],
                 lo + 1, sram_mem[lo + 1], ref_mem[lo], ref_mem[lo + 1]);
      end
      n_checks++;
      if (rdat !== last_read) begin
        n_fail++;
        $display("FAIL %s read_data hold: got %h expected %h", name, rdat, last_read);
      end
    end else begin
      exp_rd = {ref_rd(lo + 1), ref_rd(lo)};
      n_checks++;
      if (rdat !== exp_rd) begin
        n_fail++;
        $display("FAIL %s read: got %h expected %h", name, rdat, exp_rd);
      end
      last_read = exp_rd;
    end
    @(negedge clk);
  endtask

  task automatic release_bus();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; probe_en = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({read_data, we_n, oe_n, sram_addr, ready, ce_n, ub_n, lb_n} !==
        {32'h0, 1'b1, 1'b1, {AW{1'b0}}, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL reset outputs: rd=%h we_n=%b oe_n=%b addr=%h ready=%b ce/ub/lb=%b%b%b expected 0 1 1 0 1 000",
               read_data, we_n, oe_n, sram_addr, ready, ce_n, ub_n, lb_n);
    end
    @(negedge clk);
    rst = 1'b0;
    last_read = '0;
    @(negedge clk);
  endtask

  task automatic test_store();
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "store_deadbeef");
    release_bus();
    n_checks++;
    if (sram_mem[0] !== 16'hBEEF || sram_mem[1] !== 16'hDEAD) begin
      n_fail++;
      $display("FAIL store_direct: sram[0]=%h sram[1]=%h expected beef dead", sram_mem[0], sram_mem[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_load();
    sram_mem[2] = 16'h5678; ref_mem[2] = 16'h5678;
    sram_mem[3] = 16'h1234; ref_mem[3] = 16'h1234;
    access(1'b0, 1'b1, 32'd1028, 32'h0, "load_1028");
    release_bus();
    n_checks++;
    if (read_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL load_direct: got %h expected 12345678", read_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 32'd1040, 32'hA5A50F0F, "b2b_store");
    access(1'b0, 1'b1, 32'd1040, 32'h0, "b2b_load");
    release_bus();
    n_checks++;
    if (read_data !== 32'hA5A50F0F) begin
      n_fail++;
      $display("FAIL b2b_direct: got %h expected a5a50f0f", read_data);
    end
    @(negedge clk);
  endtask

  task automatic test_both_enables();
    access(1'b1, 1'b1, 32'd1024, 32'h1, "both_en");
    release_bus();
    n_checks++;
    if (sram_mem[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL both_en_direct: sram[0]=%h expected 0001", sram_mem[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_drop();
    logic [31:0] d;
    d = $urandom;
    wr_en = 1'b1; address = 32'd1032; write_data = d;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop ready_cycle0: got %b expected 0", ready);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop ready_released: got %b expected 1", ready);
    end
    repeat (2 * PH + 1) @(negedge clk);
    ref_mem[4] = d[15:0];
    ref_mem[5] = d[31:16];
    n_checks++;
    if (sram_mem[4] !== ref_mem[4] || sram_mem[5] !== ref_mem[5]) begin
      n_fail++;
      $display("FAIL drop completes: sram[4]=%h sram[5]=%h expected %h %h",
               sram_mem[4], sram_mem[5], ref_mem[4], ref_mem[5]);
    end
  endtask

  task automatic test_reset_mid_write();
    wr_en = 1'b1; address = 32'd1100; write_data = 32'h11112222;
    repeat (PH + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({we_n, oe_n, sram_addr, read_data, ready} !== {1'b1, 1'b1, {AW{1'b0}}, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_write: we_n=%b oe_n=%b addr=%h rd=%h ready=%b expected 1 1 0 0 0",
               we_n, oe_n, sram_addr, read_data, ready);
    end
    probe_en = 1'b1;
    #1;
    n_checks++;
    if (sram_dq !== 16'h3C3C) begin
      n_fail++;
      $display("FAIL reset_mid_write dq_released: got %h expected 3c3c", sram_dq);
    end
    probe_en = 1'b0;
    release_bus();
    @(negedge clk);
    rst = 1'b0;
    ref_mem[38] = sram_mem[38];
    ref_mem[39] = sram_mem[39];
    last_read = '0;
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1100, 32'h0, "after_reset_load");
    release_bus();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        wr;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 4 * $urandom_range(0, 15);
      access(wr, ~wr, a, $urandom, "random");
      if ($urandom_range(0, 1) == 1) begin
        release_bus();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    release_bus();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_pat(i);
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_both_enables();
    test_drop();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
